// File: rtl/picoramsoc_fifouart_if.sv
// rtl/picoramsoc_fifouart_if.sv - SoC I/O bus port bundle for the FIFO UART
interface picoramsoc_fifouart_if;
  logic        valid;
  logic        ready;
  logic [1:0]  addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output valid, addr, wstrb, wdata, input ready, rdata);
  modport slave  (input valid, addr, wstrb, wdata, output ready, rdata);
endinterface

// File: rtl/picoramsoc_fifouart.sv
// rtl/picoramsoc_fifouart.sv - memory-mapped UART with TX/RX FIFOs and level interrupt
module picoramsoc_fifouart #(
  parameter int          DATA_BITS = 8,
  parameter int          TX_DEPTH  = 16,
  parameter int          RX_DEPTH  = 16,
  parameter logic [31:0] DIV_RESET = 32'd104
) (
  input  logic                  clk,
  input  logic                  reset,
  picoramsoc_fifouart_if.slave  bus,
  output logic                  ser_tx,
  input  logic                  ser_rx,
  output logic                  irq
);
  localparam int             TX_AW    = $clog2(TX_DEPTH);
  localparam int             RX_AW    = $clog2(RX_DEPTH);
  localparam logic [TX_AW:0] TX_CAP   = (TX_AW + 1)'(TX_DEPTH);
  localparam logic [RX_AW:0] RX_CAP   = (RX_AW + 1)'(RX_DEPTH);
  localparam logic [3:0]     LAST_BIT = 4'(DATA_BITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [31:0] div_reg, div_eff;
  logic [2:0]  ctrl;
  logic        overrun, frame_err;

  logic        ready_q;
  logic [31:0] rdata_q, rd_val;
  logic        is_wr, accept, start;
  logic        req_wr, req_pop;
  logic [1:0]  req_addr;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;

  logic [DATA_BITS-1:0] tx_mem [TX_DEPTH];
  logic [TX_AW-1:0]     tx_wr_ptr, tx_rd_ptr;
  logic [TX_AW:0]       tx_cnt;
  logic                 tx_full, tx_empty, tx_push, tx_pop, tx_idle;

  logic [DATA_BITS-1:0] rx_mem [RX_DEPTH];
  logic [RX_AW-1:0]     rx_wr_ptr, rx_rd_ptr;
  logic [RX_AW:0]       rx_cnt;
  logic                 rx_full, rx_empty, rx_push, rx_pop;

  state_t               tx_state, rx_state;
  logic [31:0]          tx_tick, tx_period, rx_tick, rx_period;
  logic [3:0]           tx_bit, rx_bit;
  logic [DATA_BITS-1:0] tx_shift, rx_shift;
  logic                 tx_bit_end, rx_sample, rx_stop_done;
  logic                 rx_s1, rx_s2, ovr_set, ferr_set;

  logic [8:0]  tx_cnt9, rx_cnt9;
  logic [7:0]  tx_level, rx_level;
  logic [31:0] status;

  assign div_eff  = (div_reg < 32'd2) ? 32'd2 : div_reg;
  assign tx_full  = (tx_cnt == TX_CAP);
  assign tx_empty = (tx_cnt == '0);
  assign rx_full  = (rx_cnt == RX_CAP);
  assign rx_empty = (rx_cnt == '0);
  assign tx_idle  = tx_empty && (tx_state == S_IDLE);

  assign tx_cnt9  = 9'(tx_cnt);
  assign rx_cnt9  = 9'(rx_cnt);
  assign tx_level = tx_cnt9[8] ? 8'hFF : tx_cnt9[7:0];
  assign rx_level = rx_cnt9[8] ? 8'hFF : rx_cnt9[7:0];
  assign status   = {8'd0, tx_level, rx_level, 3'd0, frame_err, overrun, tx_idle, tx_full, !rx_empty};

  // Requests are latched at acceptance; side effects commit in the ready cycle.
  assign is_wr  = |bus.wstrb;
  assign accept = !(bus.addr == 2'd1 && is_wr && tx_full);
  assign start  = bus.valid && !ready_q && accept;

  always_comb begin
    rd_val = 32'd0;
    case (bus.addr)
      2'd0: rd_val = div_reg;
      2'd1: rd_val = rx_empty ? 32'hFFFF_FFFF : 32'(rx_mem[rx_rd_ptr]);
      2'd2: rd_val = status;
      default: rd_val = {29'd0, ctrl};
    endcase
  end

  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q   <= 1'b0;
      rdata_q   <= 32'd0;
      req_wr    <= 1'b0;
      req_pop   <= 1'b0;
      req_addr  <= 2'd0;
      req_wstrb <= 4'd0;
      req_wdata <= 32'd0;
    end else begin
      ready_q <= start;
      rdata_q <= (start && !is_wr) ? rd_val : 32'd0;
      if (start) begin
        req_wr    <= is_wr;
        req_pop   <= !is_wr && bus.addr == 2'd1 && !rx_empty;
        req_addr  <= bus.addr;
        req_wstrb <= bus.wstrb;
        req_wdata <= bus.wdata;
      end
    end
  end

  assign tx_push = ready_q && req_wr && req_addr == 2'd1 && req_wstrb[0];
  assign rx_pop  = ready_q && req_pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_reg   <= DIV_RESET;
      ctrl      <= 3'd0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      irq       <= 1'b0;
    end else begin
      if (ready_q && req_wr) begin
        case (req_addr)
          2'd0: for (int i = 0; i < 4; i++)
                  if (req_wstrb[i]) div_reg[8*i +: 8] <= req_wdata[8*i +: 8];
          2'd2: if (req_wstrb[0]) begin
                  if (req_wdata[3]) overrun   <= 1'b0;
                  if (req_wdata[4]) frame_err <= 1'b0;
                end
          2'd3: if (req_wstrb[0]) ctrl <= req_wdata[2:0];
          default: ;
        endcase
      end
      if (ovr_set)  overrun   <= 1'b1;
      if (ferr_set) frame_err <= 1'b1;
      irq <= (ctrl[0] && !rx_empty) || (ctrl[1] && tx_idle) || (ctrl[2] && (overrun || frame_err));
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= req_wdata[DATA_BITS-1:0];
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_shift;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_cnt    <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_cnt    <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: ;
      endcase
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // Bit period is re-latched at every bit boundary so DIV edits never stretch a bit.
  assign tx_bit_end = (tx_tick == tx_period - 32'd1);
  assign tx_pop     = !tx_empty && (tx_state == S_IDLE || (tx_state == S_STOP && tx_bit_end));

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state  <= S_IDLE;
      ser_tx    <= 1'b1;
      tx_tick   <= 32'd0;
      tx_period <= DIV_RESET;
      tx_bit    <= 4'd0;
      tx_shift  <= '0;
    end else begin
      case (tx_state)
        S_IDLE: if (tx_pop) begin
          tx_state  <= S_START;
          ser_tx    <= 1'b0;
          tx_shift  <= tx_mem[tx_rd_ptr];
          tx_tick   <= 32'd0;
          tx_period <= div_eff;
        end
        S_START: if (tx_bit_end) begin
          tx_state  <= S_DATA;
          ser_tx    <= tx_shift[0];
          tx_shift  <= tx_shift >> 1;
          tx_bit    <= 4'd0;
          tx_tick   <= 32'd0;
          tx_period <= div_eff;
        end else tx_tick <= tx_tick + 32'd1;
        S_DATA: if (tx_bit_end) begin
          tx_tick   <= 32'd0;
          tx_period <= div_eff;
          if (tx_bit == LAST_BIT) begin
            tx_state <= S_STOP;
            ser_tx   <= 1'b1;
          end else begin
            tx_bit   <= tx_bit + 4'd1;
            ser_tx   <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
          end
        end else tx_tick <= tx_tick + 32'd1;
        default: if (tx_bit_end) begin
          tx_tick   <= 32'd0;
          tx_period <= div_eff;
          if (tx_pop) begin
            tx_state <= S_START;
            ser_tx   <= 1'b0;
            tx_shift <= tx_mem[tx_rd_ptr];
          end else tx_state <= S_IDLE;
        end else tx_tick <= tx_tick + 32'd1;
      endcase
    end
  end

  // A CPU pop in the same cycle frees the slot a full FIFO needs, so that push is not an overrun.
  assign rx_sample    = (rx_tick == rx_period - 32'd1);
  assign rx_stop_done = (rx_state == S_STOP) && rx_sample;
  assign rx_push      = rx_stop_done && rx_s2 && !(rx_full && !rx_pop);
  assign ovr_set      = rx_stop_done && rx_s2 && rx_full && !rx_pop;
  assign ferr_set     = rx_stop_done && !rx_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_state  <= S_IDLE;
      rx_tick   <= 32'd0;
      rx_period <= DIV_RESET;
      rx_bit    <= 4'd0;
      rx_shift  <= '0;
    end else begin
      rx_s1 <= ser_rx;
      rx_s2 <= rx_s1;
      case (rx_state)
        S_IDLE: if (!rx_s2) begin
          rx_state  <= S_START;
          rx_tick   <= 32'd0;
          rx_period <= div_eff;
        end
        S_START: if (rx_tick == (rx_period >> 1) - 32'd1) begin
          rx_state  <= rx_s2 ? S_IDLE : S_DATA;
          rx_bit    <= 4'd0;
          rx_tick   <= 32'd0;
          rx_period <= div_eff;
        end else rx_tick <= rx_tick + 32'd1;
        S_DATA: if (rx_sample) begin
          rx_shift  <= {rx_s2, rx_shift[DATA_BITS-1:1]};
          rx_tick   <= 32'd0;
          rx_period <= div_eff;
          if (rx_bit == LAST_BIT) rx_state <= S_STOP;
          else rx_bit <= rx_bit + 4'd1;
        end else rx_tick <= rx_tick + 32'd1;
        default: if (rx_sample) begin
          rx_state <= S_IDLE;
          rx_tick  <= 32'd0;
        end else rx_tick <= rx_tick + 32'd1;
      endcase
    end
  end
endmodule

// File: tb/tb_picoramsoc_fifouart.sv
// tb/tb_picoramsoc_fifouart.sv - scoreboard bench for the FIFO UART
module tb_picoramsoc_fifouart;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx_line = 1'b1;
  logic loopback = 1'b0;
  logic ser_tx, ser_rx, irq;

  picoramsoc_fifouart_if bus();

  picoramsoc_fifouart #(
    .DATA_BITS(8), .TX_DEPTH(4), .RX_DEPTH(2), .DIV_RESET(32'd104)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .ser_tx(ser_tx), .ser_rx(ser_rx), .irq(irq)
  );

  assign ser_rx = loopback ? ser_tx : rx_line;

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int c5, c6, dummy;
  logic [7:0] exp_bytes [8];

  logic [31:0] sb_exp [$];
  bit          sb_chk [$];
  string       sb_name [$];

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  always @(negedge clk) begin : monitor
    logic [31:0] e;
    bit          c;
    string       nm;
    if (bus.ready === 1'b1) begin
      if (sb_exp.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_ready: got ready=1 expected no pending transaction");
      end else begin
        e  = sb_exp.pop_front();
        c  = sb_chk.pop_front();
        nm = sb_name.pop_front();
        if (c) begin
          n_checks++;
          if (bus.rdata === e) n_pass++;
          else $display("FAIL %s: got %h expected %h", nm, bus.rdata, e);
        end
      end
    end
  end

  task automatic bus_xfer(input logic [1:0] a, input logic [3:0] s, input logic [31:0] d,
                          input bit chk, input logic [31:0] exp, input string nm, output int cyc);
    int n;
    bit done;
    sb_exp.push_back(exp);
    sb_chk.push_back(chk);
    sb_name.push_back(nm);
    bus.addr = a; bus.wstrb = s; bus.wdata = d; bus.valid = 1'b1;
    n = 0;
    done = 1'b0;
    while (!done && n < 500) begin
      @(posedge clk); #1;
      n++;
      done = (bus.ready === 1'b1);
    end
    if (!done) begin
      n_checks++;
      $display("FAIL %s_timeout: got no ready expected ready within 500 cycles", nm);
      sb_exp.delete(sb_exp.size() - 1);
      sb_chk.delete(sb_chk.size() - 1);
      sb_name.delete(sb_name.size() - 1);
    end
    bus.valid = 1'b0;
    bus.wstrb = 4'd0;
    cyc = n;
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] s, input logic [31:0] d, output int cyc);
    bus_xfer(a, s, d, 1'b0, 32'd0, "write", cyc);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
    int cyc;
    bus_xfer(a, 4'd0, 32'd0, 1'b1, exp, nm, cyc);
  endtask

  task automatic tx_check(input int nf);
    int n;
    logic [39:0] got, exp;
    logic [9:0] f;
    n = 0;
    while (ser_tx !== 1'b0 && n < 300) begin @(posedge clk); #1; n++; end
    if (ser_tx !== 1'b0) check("tx_start_seen", 64'(ser_tx), 64'd0);
    for (int fr = 0; fr < nf; fr++) begin
      f = {1'b1, exp_bytes[fr], 1'b0};
      for (int i = 0; i < 40; i++) begin
        got[i] = ser_tx;
        exp[i] = f[i/4];
        @(posedge clk); #1;
      end
      check($sformatf("tx_frame%0d", fr), 64'(got), 64'(exp));
    end
  endtask

  task automatic rx_send(input logic [7:0] b, input bit stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_line = f[i];
      repeat (4) @(posedge clk);
      #1;
    end
    rx_line = 1'b1;
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    bus.valid = 1'b0; bus.addr = 2'd0; bus.wstrb = 4'd0; bus.wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("reset_ser_tx", 64'(ser_tx), 64'd1);
    check("reset_irq", 64'(irq), 64'd0);
    check("reset_ready", 64'(bus.ready), 64'd0);
    check("reset_rdata", 64'(bus.rdata), 64'd0);
    rd(2'd2, 32'h0000_0004, "reset_status");
    rd(2'd0, 32'd104, "reset_div");
    rd(2'd3, 32'd0, "reset_ctrl");

    // Byte-lane write: only the low byte of DIV changes (0x68 -> 0x04)
    wr(2'd0, 4'b0001, 32'h1234_5604, dummy);
    rd(2'd0, 32'd4, "div_byte_write");

    exp_bytes[0] = 8'hA5;
    wr(2'd1, 4'b0001, 32'h0000_00A5, dummy);
    @(posedge clk); #1;
    check("tx_latency_still_high", 64'(ser_tx), 64'd1);
    @(posedge clk); #1;
    check("tx_latency_low", 64'(ser_tx), 64'd0);
    tx_check(1);
    rd(2'd2, 32'h0000_0004, "tx_idle_after_frame");

    // TX_DEPTH=4: first byte is popped at once, so the 6th write is the one that stalls
    exp_bytes[0] = 8'h11; exp_bytes[1] = 8'h22; exp_bytes[2] = 8'h33;
    exp_bytes[3] = 8'h44; exp_bytes[4] = 8'h55; exp_bytes[5] = 8'h66;
    fork
      begin
        for (int i = 0; i < 4; i++) wr(2'd1, 4'b0001, 32'(exp_bytes[i]), dummy);
        wr(2'd1, 4'b0001, 32'(exp_bytes[4]), c5);
        wr(2'd1, 4'b0001, 32'(exp_bytes[5]), c6);
      end
      tx_check(6);
    join
    check("w5_latency", 64'(c5), 64'd2);
    check("w6_stall_latency", 64'(c6), 64'd35);

    loopback = 1'b1;
    wr(2'd3, 4'b0001, 32'd1, dummy);
    wr(2'd1, 4'b0001, 32'h0000_003C, dummy);
    check("irq_before_rx", 64'(irq), 64'd0);
    n = 0;
    while (irq !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    check("irq_rx_rise", 64'(irq), 64'd1);
    rd(2'd1, 32'h0000_003C, "loop_data");
    rd(2'd1, 32'hFFFF_FFFF, "loop_empty_read");
    check("irq_fall", 64'(irq), 64'd0);
    loopback = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    rx_send(8'h81, 1'b1);
    rx_send(8'h42, 1'b1);
    rx_send(8'hE7, 1'b1);
    rd(2'd2, 32'h0000_020D, "overrun_status");
    rd(2'd1, 32'h0000_0081, "rx_byte0");
    rd(2'd1, 32'h0000_0042, "rx_byte1");
    wr(2'd2, 4'b0001, 32'h0000_0008, dummy);
    rd(2'd2, 32'h0000_0004, "overrun_cleared");

    rx_send(8'h55, 1'b0);
    rd(2'd2, 32'h0000_0014, "frame_err_status");
    rx_line = 1'b0;
    @(posedge clk); #1;
    rx_line = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    rd(2'd2, 32'h0000_0014, "glitch_no_change");
    wr(2'd2, 4'b0001, 32'h0000_0018, dummy);
    rd(2'd2, 32'h0000_0004, "frame_err_cleared");

    wr(2'd1, 4'b0001, 32'h0000_0000, dummy);
    repeat (10) @(posedge clk);
    #1;
    check("mid_tx_low", 64'(ser_tx), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("reset_mid_tx_ser_tx", 64'(ser_tx), 64'd1);
    reset = 1'b0;
    check("reset_mid_tx_irq", 64'(irq), 64'd0);
    rd(2'd2, 32'h0000_0004, "post_reset_status");
    rd(2'd0, 32'd104, "post_reset_div");
    rd(2'd3, 32'd0, "post_reset_ctrl");
    repeat (4) @(posedge clk);
    #1;
    check("post_reset_line_idle", 64'(ser_tx), 64'd1);
    check("scoreboard_drained", 64'(sb_exp.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
